// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit with HI/LO registers.
// Multiply is shift-add, divide is restoring; both run on operand magnitudes
// and apply the sign fix-up in the final state. A fixed N-cycle iteration
// phase plus one finish cycle gives N+1 cycles of busy.
// Optional macro MDU_ZERO_SKIP_EN: trivially-zero multiplies and
// divide-by-zero jump straight from IDLE to FIN (busy for one cycle).
module mult_div_unit #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [N-1:0]  inA,
    input  logic [N-1:0]  inB,
    input  logic          hi_wen,
    input  logic          lo_wen,
    input  logic [N-1:0]  wd,
    output logic          busy,
    output logic          done,
    output logic          dbz,
    output logic [N-1:0]  hi,
    output logic [N-1:0]  lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Two's-complement negation of an N-bit value.
    function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
        return ~x + N'(1);
    endfunction

    // Two's-complement negation of a 2N-bit value.
    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] x);
        return ~x + (2*N)'(1);
    endfunction

    // Magnitude of x when treated as signed, otherwise x itself.
    function automatic logic [N-1:0] abs_n(input logic [N-1:0] x, input logic sgn);
        if (sgn && x[N-1]) begin
            return neg_n(x);
        end else begin
            return x;
        end
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;          // product / quotient negated
    logic            neg_rem_q, neg_rem_d;  // remainder negated (dividend sign)
    logic            bzero_q, bzero_d;      // divisor was zero
    logic [N-1:0]    raw_a_q, raw_a_d;      // dividend as issued, for div-by-zero
    logic [N-1:0]    operand_q, operand_d;  // multiplicand or divisor magnitude
    logic [N-1:0]    acc_q, acc_d;          // product upper half / partial remainder
    logic [N-1:0]    work_lo_q, work_lo_d;  // multiplier -> product low / dividend -> quotient
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;

    logic            op_signed_s;
    logic [N-1:0]    mag_a_s, mag_b_s;
    logic [N:0]      mult_sum_s;
    logic [N:0]      rem_shift_s;
    logic [N-1:0]    div_diff_s;
    logic            div_ge_s;
    logic [2*N-1:0]  prod_s;

    // Operand magnitudes and the per-iteration datapath results.
    always_comb begin
        op_signed_s = ~op[0];
        mag_a_s     = abs_n(inA, op_signed_s);
        mag_b_s     = abs_n(inB, op_signed_s);
        mult_sum_s  = {1'b0, acc_q} + {1'b0, operand_q};
        rem_shift_s = {acc_q, work_lo_q[N-1]};
        div_diff_s  = rem_shift_s[N-1:0] - operand_q;
        div_ge_s    = (rem_shift_s >= {1'b0, operand_q});
        prod_s      = neg_q ? neg_2n({acc_q, work_lo_q}) : {acc_q, work_lo_q};
    end

    // Next-state logic: FSM sequencing, iteration step, result and HI/LO writes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        raw_a_d   = raw_a_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        work_lo_d = work_lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_d     = op_signed_s & (inA[N-1] ^ inB[N-1]);
                    neg_rem_d = op_signed_s & inA[N-1];
                    bzero_d   = (inB == '0);
                    raw_a_d   = inA;
                    operand_d = op[1] ? mag_b_s : mag_a_s;
                    acc_d     = '0;
                    work_lo_d = op[1] ? mag_a_s : mag_b_s;
                    cnt_d     = CW'(N - 1);
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
`ifdef MDU_ZERO_SKIP_EN
                    // Zero product or divide-by-zero: result is known now.
                    if ((!op[1] && (inA == '0 || inB == '0)) || (op[1] && inB == '0)) begin
                        work_lo_d = '0;
                        state_d   = ST_FIN;
                    end else begin
                        state_d   = ST_RUN;
                    end
`endif
                end else begin
                    // Direct MTHI/MTLO writes only when idle and no start.
                    if (hi_wen) begin
                        hi_d = wd;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (lo_wen) begin
                        lo_d = wd;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end

            ST_RUN: begin
                if (is_div_q) begin
                    // Restoring divide: shift in next dividend bit, subtract if it fits.
                    acc_d     = div_ge_s ? div_diff_s : rem_shift_s[N-1:0];
                    work_lo_d = {work_lo_q[N-2:0], div_ge_s};
                end else begin
                    // Shift-add multiply: conditionally add, then shift right by one.
                    if (work_lo_q[0]) begin
                        acc_d     = mult_sum_s[N:1];
                        work_lo_d = {mult_sum_s[0], work_lo_q[N-1:1]};
                    end else begin
                        acc_d     = {1'b0, acc_q[N-1:1]};
                        work_lo_d = {acc_q[0], work_lo_q[N-1:1]};
                    end
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_FIN: begin
                if (is_div_q) begin
                    if (bzero_q) begin
                        lo_d  = '1;
                        hi_d  = raw_a_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d  = neg_q ? neg_n(work_lo_q) : work_lo_q;
                        hi_d  = neg_rem_q ? neg_n(acc_q) : acc_q;
                        dbz_d = 1'b0;
                    end
                end else begin
                    hi_d  = prod_s[2*N-1:N];
                    lo_d  = prod_s[N-1:0];
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            raw_a_q   <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            work_lo_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            raw_a_q   <= raw_a_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            work_lo_q <= work_lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit (N=32): directed vectors with literal
// expectations plus a per-cycle comparison against an arithmetic model.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] inA = 32'd0;
    logic [31:0] inB = 32'd0;
    logic        hi_wen = 1'b0;
    logic        lo_wen = 1'b0;
    logic [31:0] wd = 32'd0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int n_vec  = 0;
    int n_fail = 0;

`ifdef MDU_ZERO_SKIP_EN
    localparam int LAT_DZ = 1;
`else
    localparam int LAT_DZ = 33;
`endif

    mult_div_unit #(.N(32), .CW(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .inA(inA), .inB(inB), .hi_wen(hi_wen), .lo_wen(lo_wen), .wd(wd),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {dbz, hi, lo} computed with plain arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin p = 64'(sa * sb); return {1'b0, p}; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, 32'h80000000};
                return {1'b0, 32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_ZERO_SKIP_EN
        if (!o[1] && (a == 32'd0 || b == 32'd0)) return 1;
        if (o[1] && b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // Model state: outstanding operation tracked as cycles remaining.
    logic        m_valid = 1'b0;
    logic        m_busy, m_done, m_dbz;
    logic [31:0] m_hi, m_lo;
    logic [64:0] m_pend;
    int          m_left;

    // Model update at each rising edge from the inputs presented in that cycle.
    always @(posedge clock) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_dbz   <= 1'b0;
            m_hi    <= 32'd0;
            m_lo    <= 32'd0;
            m_left  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_dbz  <= m_pend[64];
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (start) begin
                m_pend <= ref_op(op, inA, inB);
                m_left <= ref_lat(op, inA, inB);
                m_busy <= 1'b1;
            end else begin
                if (hi_wen) m_hi <= wd;
                if (lo_wen) m_lo <= wd;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("cycle", {busy, done, dbz, hi, lo}, {m_busy, m_done, m_dbz, m_hi, m_lo});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; inA = a; inB = b;
        tick();
        start = 1'b0; inA = 32'hDEADBEEF; inB = 32'h0BADF00D; op = ~o;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 200);
        if (cyc >= 200) chk("done timeout", 128'(done), 128'(1'b1));
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int elat);
        int c;
        issue(o, a, b);
        wait_done(c);
        chk({name, " latency"}, 128'(c), 128'(elat));
        chk({name, " hi"}, 128'(hi), 128'(ehi));
        chk({name, " lo"}, 128'(lo), 128'(elo));
        chk({name, " dbz"}, 128'(dbz), 128'(edbz));
    endtask

    initial begin
        int c;
        logic saw_done;
        tick();
        tick();
        reset = 1'b0;
        chk("reset state", {busy, done, dbz, hi, lo}, 99'd0);

        // Pin the model against hand-computed results.
        chk("model mult", 128'(ref_op(2'd0, 32'hFFFFFFFD, 32'd5)), {1'b0, 64'hFFFFFFFF_FFFFFFF1});
        chk("model div ovf", 128'(ref_op(2'd2, 32'h80000000, 32'hFFFFFFFF)), {1'b0, 64'h00000000_80000000});

        run_op("mult -3*5", 2'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
        run_op("multu max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        chk("busy in done cycle", 128'(busy), 128'(1'b0));
        run_op("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
        run_op("div -7/2", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        run_op("div ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33);
        run_op("divu by 0", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, LAT_DZ);
        run_op("mult 2*3", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33);

        // Start and HI/LO writes while busy must be ignored.
        issue(2'd1, 32'd7, 32'd9);
        repeat (3) tick();
        start = 1'b1; op = 2'd3; inA = 32'd5; inB = 32'd0;
        hi_wen = 1'b1; lo_wen = 1'b1; wd = 32'h12345678;
        tick();
        start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
        wait_done(c);
        chk("busy-ignore hi", 128'(hi), 128'(32'd0));
        chk("busy-ignore lo", 128'(lo), 128'(32'd63));
        chk("busy-ignore dbz", 128'(dbz), 128'(1'b0));
        tick();

        // Direct LO write in idle.
        lo_wen = 1'b1; wd = 32'h12345678;
        tick();
        lo_wen = 1'b0;
        chk("mtlo lo", 128'(lo), 128'(32'h12345678));
        chk("mtlo hi", 128'(hi), 128'(32'd0));

        // Reset mid-operation aborts without a done pulse.
        issue(2'd0, 32'd3, 32'd4);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort state", {busy, done, hi, lo}, 66'd0);
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            saw_done = saw_done | done;
        end
        chk("abort no done", 128'(saw_done), 128'(1'b0));
        run_op("mult after reset", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO result registers, the multi-cycle companion to the single-cycle datapath ALU.
- Executes signed/unsigned multiply and divide over N-bit operands with a start/busy/done handshake.
- The core stalls MFHI/MFLO and further mult/div issue while busy is high.
- Also supports direct HI/LO writes for MTHI/MTLO.

Parameters:
- N, 32: operand width; HI and LO are each N bits; must be even and at least 4.
- CW, 6: iteration counter width; must satisfy 2^CW > N.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  request operation; sampled only when busy=0.
- op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- inA  input  N  multiplicand / dividend.
- inB  input  N  multiplier / divisor.
- hi_wen  input  1  write wd into HI (MTHI).
- lo_wen  input  1  write wd into LO (MTLO).
- wd  input  N  HI/LO write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- dbz  output  1  divide-by-zero flag of the last completed operation.
- hi  output  N  HI register: product upper half / remainder.
- lo  output  N  LO register: product lower half / quotient.

Behaviour:
- Reset: synchronous and active-high, applied at the rising edge of clock. It clears busy, done, dbz, hi, lo, the counter and internal working registers, and the FSM returns to IDLE. Reset mid-operation aborts the operation: no done pulse, and HI/LO are not updated with a partial result.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start=1, latch op, |inA|, |inB| (magnitudes for signed ops) and the result signs; load the counter with N-1; go to RUN. busy=1 from the next cycle.
- RUN:
  - One radix-2 iteration per cycle: shift-add multiply, or restoring divide.
  - The counter decrements each cycle; when it is 0, go to FIN. RUN lasts exactly N cycles.
- FIN:
  - Apply sign fix-up, write HI/LO, set dbz, pulse done. busy=0 and return to IDLE at the same edge.
- Latency: if start is sampled at edge E0, the result appears in hi/lo with done=1 after edge E0+N+1. busy is high for exactly N+1 cycles.
- Back-to-back issue: a new start is accepted in the cycle done=1, since busy=0 there.
- start while busy=1 is ignored; op/inA/inB changes during busy have no effect.
- Multiply: the full 2N-bit product goes to {hi, lo}. Signed multiply negates the magnitude product when the operand signs differ.
- Divide:
  - Quotient to lo, remainder to hi.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero:
  - lo = all ones; hi = inA unchanged; dbz=1.
  - Still takes the full latency.
- Signed overflow (most-negative / -1): lo = most-negative value, hi = 0, dbz=0.
- dbz is cleared to 0 on completion of any non-zero-divisor op and holds its value between completions.
- HI/LO writes:
  - hi_wen/lo_wen take effect at the rising edge only when busy=0 and start=0.
  - While busy=1, or in the same cycle as an accepted start, they are ignored (start wins).
  - hi_wen and lo_wen may both be 1: both registers get wd.
- hi/lo are held constant while busy=1; intermediate values live in internal registers only.

Optional Feature:
- Macro: MDU_ZERO_SKIP_EN.
- Defined: if the IDLE state sees start with a multiply where inA=0 or inB=0, or a divide where inB=0, the FSM goes directly to FIN.
  - Results follow the same rules as the full-latency path: product 0; divide-by-zero result as above.
  - done asserts after edge E0+1; busy is high for 1 cycle.
- Not defined: every operation takes the fixed N+1-cycle latency.

Test Plan (N=32):
- mult inA=FFFFFFFD (-3), inB=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1, dbz=0; done exactly 33 cycles after the start edge, busy high 33 cycles.
- multu FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001; then immediately start in the done cycle: divu 00000064/00000007 -> lo=0000000E, hi=00000002.
- div FFFFFFF9 (-7) / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. div 80000000 / FFFFFFFF -> lo=80000000, hi=00000000, dbz=0.
- divu 00000064 / 0 -> lo=FFFFFFFF, hi=00000064, dbz=1, done after 33 cycles without the macro, after 1 cycle with it. A following mult 2x3 clears dbz, giving lo=6.
- During busy: pulse start with new operands and assert hi_wen/lo_wen with wd=12345678 -> both ignored, original result delivered. In IDLE, lo_wen with wd=12345678 -> lo=12345678, hi unchanged.
- Assert reset for one cycle 10 cycles into a mult -> next cycle busy=0, done=0, hi=lo=0, no done pulse follows. A new start is then accepted normally.
